pc_gen: RTL

//  Parametrised fetch program-counter generator for the 5-stage core, replacing the fixed 32-bit PC.

---
 rtl/pc_gen.sv | 68 ++++++
 1 files changed

// File: rtl/pc_gen.sv
// pc_gen: fetch program-counter generator with an optional direct-mapped BTB.
// Define PC_BTB_EN to build the branch target buffer; otherwise prediction is plain pc+4.
module pc_gen #(
    parameter int              XLEN        = 32,
    parameter logic [XLEN-1:0] RESET_VEC   = '0,
    parameter int              BTB_ENTRIES = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            trap_valid,
    input  logic [XLEN-1:0] trap_addr,
    input  logic            br_ctrl,
    input  logic [XLEN-1:0] br_addr,
    input  logic            pc_stall,
    input  logic            upd_valid,
    input  logic [XLEN-1:0] upd_pc,
    input  logic [XLEN-1:0] upd_target,
    input  logic            upd_taken,
    output logic [XLEN-1:0] pc_o,
    output logic            pred_o,
    output logic [XLEN-1:0] pred_tgt_o
);
    logic [XLEN-1:0] pc_q, pc_d, seq_pc;
    assign seq_pc = pc_q + XLEN'(4);
    assign pc_o   = pc_q;
    always_comb begin
        pc_d = trap_valid ? {trap_addr[XLEN-1:2], 2'b00} :
               br_ctrl    ? {br_addr[XLEN-1:2], 2'b00}   :
               pc_stall   ? pc_q                         : pred_tgt_o;
    end
    always_ff @(posedge clk) begin
        pc_q <= !rst ? RESET_VEC : pc_d;
    end
`ifdef PC_BTB_EN
    localparam int IDX_W = $clog2(BTB_ENTRIES);
    localparam int TAG_W = XLEN - 2 - IDX_W;
    logic [BTB_ENTRIES-1:0] valid_q;
    logic [TAG_W-1:0]       tag_q [BTB_ENTRIES];
    logic [XLEN-3:0]        tgt_q [BTB_ENTRIES];
    logic [IDX_W-1:0]       rd_idx, wr_idx;
    logic                   hit, upd_match, unused_bits;
    assign rd_idx      = pc_q[IDX_W+1:2];
    assign wr_idx      = upd_pc[IDX_W+1:2];
    assign hit         = valid_q[rd_idx] && (tag_q[rd_idx] == pc_q[XLEN-1:IDX_W+2]);
    assign upd_match   = tag_q[wr_idx] == upd_pc[XLEN-1:IDX_W+2];
    assign pred_o      = hit;
    assign pred_tgt_o  = hit ? {tgt_q[rd_idx], 2'b00} : seq_pc;
    assign unused_bits = ^{trap_addr[1:0], br_addr[1:0], upd_pc[1:0], upd_target[1:0]};
    // Not-taken only drops an entry that belongs to this PC; aliases are left alone.
    always_ff @(posedge clk) begin
        if (!rst)
            valid_q <= '0;
        else if (upd_valid && (upd_taken || upd_match))
            valid_q[wr_idx] <= upd_taken;
    end
    always_ff @(posedge clk) begin
        if (rst && upd_valid && upd_taken) begin
            tag_q[wr_idx] <= upd_pc[XLEN-1:IDX_W+2];
            tgt_q[wr_idx] <= upd_target[XLEN-1:2];
        end
    end
`else
    logic unused_bits;
    assign pred_o      = 1'b0;
    assign pred_tgt_o  = seq_pc;
    assign unused_bits = ^{trap_addr[1:0], br_addr[1:0], upd_valid, upd_pc, upd_target, upd_taken};
`endif
endmodule
